// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock AXI-Stream FIFO with first-word-fall-through output,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
// Optional packet mode is enabled by defining AXIS_FIFO_PKT_MODE_EN.
module axis_sync_fifo #(
  parameter int DWIDTH        = 16,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [DWIDTH-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);

  logic [DWIDTH:0] mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic [DWIDTH:0] head_s;
  logic            full_s;
  logic            empty_s;
  logic            clr_s;
  logic            wr_fire_s;
  logic            rd_fire_s;

  // Reset and flush share one clear path; rstn simply dominates by being OR-ed in.
  assign clr_s     = !rstn || flush;
  assign full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s   = (wptr_q == rptr_q);
  assign wr_fire_s = s_axis_tvalid && s_axis_tready;
  assign rd_fire_s = m_axis_tvalid && m_axis_tready;
  assign head_s    = mem_q[rptr_q[AW-1:0]];

  assign s_axis_tready = !full_s;
  assign m_axis_tdata  = head_s[DWIDTH-1:0];
  assign m_axis_tlast  = head_s[DWIDTH];
  assign count         = count_q;
  assign almost_full   = (count_q >= AFULL_L);
  assign almost_empty  = (count_q <= AEMPTY_L);

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_s) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_fire_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_fire_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    wptr_q  <= wptr_d;
    rptr_q  <= rptr_d;
    count_q <= count_d;
  end

  // Storage is never cleared; a beat offered during clear is dropped.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !clr_s) begin
      mem_q[wptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_wr_s;
  logic          pkt_rd_s;

  assign pkt_wr_s = wr_fire_s && s_axis_tlast;
  assign pkt_rd_s = rd_fire_s && head_s[DWIDTH];

  // Full forces release so packets longer than DEPTH cannot deadlock.
  assign m_axis_tvalid = !empty_s && ((pkt_cnt_q != '0) || full_s);

  // Next-state for the complete-packet counter.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (clr_s) begin
      pkt_cnt_d = '0;
    end else begin
      case ({pkt_wr_s, pkt_rd_s})
        2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
        2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
    end
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    pkt_cnt_q <= pkt_cnt_d;
  end
`else
  assign m_axis_tvalid = !empty_s;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo (DEPTH=8, DWIDTH=16): a vector table for fill/drain
// plus hand sequences for wrap, flush/reset, latency and (when defined) packet mode.
module tb_axis_sync_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] count;
  logic          afull;
  logic          aempty;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_cnt  = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic          svalid;
    logic [DW-1:0] sdata;
    logic          mready;
    logic          e_sready;
    logic          e_mvalid;
    logic [DW-1:0] e_mdata;
    logic [CW-1:0] e_count;
    logic          e_af;
    logic          e_ae;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  axis_sync_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .count(count), .almost_full(afull), .almost_empty(aempty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic sv, input logic [DW-1:0] sd, input logic mr,
                     input logic es, input logic ev, input logic [DW-1:0] ed,
                     input logic [CW-1:0] ec, input logic eaf, input logic eae);
    vec_t v;
    v.svalid = sv; v.sdata = sd; v.mready = mr;
    v.e_sready = es; v.e_mvalid = ev; v.e_mdata = ed;
    v.e_count = ec; v.e_af = eaf; v.e_ae = eae;
    vq.push_back(v);
  endtask

  // Handshake model: occupancy implied by fired beats must match count.
  always @(posedge clk) begin
    if (!rstn || flush) mdl_cnt <= 0;
    else mdl_cnt <= mdl_cnt + int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
  end

  always @(negedge clk) begin
    if (mon_en) chk("count_vs_handshakes", 32'(count), mdl_cnt);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic run_table();
    // fill: 0x0001..0x0008 with consumer stalled, then 0x0009 held off
    add(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
    add(1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd1, 1'b0, 1'b1);
    add(1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd2, 1'b0, 1'b0);
    add(1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd3, 1'b0, 1'b0);
    add(1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd4, 1'b0, 1'b0);
    add(1'b1, 16'h0006, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd5, 1'b0, 1'b0);
    add(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd6, 1'b1, 1'b0);
    add(1'b1, 16'h0008, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd7, 1'b1, 1'b0);
    add(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd8, 1'b1, 1'b0);
    add(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd8, 1'b1, 1'b0);
    // drain from full
    add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 4'd8, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd7, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 4'd6, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004, 4'd5, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0005, 4'd4, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0006, 4'd3, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0007, 4'd2, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0008, 4'd1, 1'b0, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].svalid, vq[i].sdata, 1'b0, vq[i].mready);
      #1;
      chk($sformatf("v%0d.s_tready", i), 32'(s_tready), 32'(vq[i].e_sready));
      chk($sformatf("v%0d.m_tvalid", i), 32'(m_tvalid), 32'(vq[i].e_mvalid));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vq[i].e_count));
      chk($sformatf("v%0d.almost_full", i), 32'(afull), 32'(vq[i].e_af));
      chk($sformatf("v%0d.almost_empty", i), 32'(aempty), 32'(vq[i].e_ae));
      if (vq[i].e_mvalid) begin
        chk($sformatf("v%0d.m_tdata", i), 32'(m_tdata), 32'(vq[i].e_mdata));
        chk($sformatf("v%0d.m_tlast", i), 32'(m_tlast), 32'h0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_wrap();
    int rd;
    rd = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 5; i <= 20; i++) begin
      drive(1'b1, 16'(16'h0100 + i), i == 20, 1'b1);
      #1;
      chk("wrap.count", 32'(count), 32'd4);
      chk("wrap.m_tvalid", 32'(m_tvalid), 32'h1);
      chk("wrap.m_tdata", 32'(m_tdata), 32'(16'h0100 + rd));
      chk("wrap.m_tlast", 32'(m_tlast), 32'(rd == 20));
      rd++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      #1;
      chk("wrap.drain_tdata", 32'(m_tdata), 32'(16'h0100 + rd));
      chk("wrap.drain_tlast", 32'(m_tlast), 32'(rd == 20));
      rd++;
      @(posedge clk);
      #1;
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("wrap.end_count", 32'(count), 32'd0);
    chk("wrap.end_tvalid", 32'(m_tvalid), 32'h0);
  endtask

  task automatic run_clear(input bit use_rst);
    string tag;
    tag = use_rst ? "rst" : "flush";
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      tick();
    end
    chk({tag, ".pre_count"}, 32'(count), 32'd3);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b1);
    if (use_rst) rstn = 1'b0;
    else flush = 1'b1;
    tick();
    rstn  = 1'b1;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".m_tvalid"}, 32'(m_tvalid), 32'h0);
    chk({tag, ".s_tready"}, 32'(s_tready), 32'h1);
    chk({tag, ".almost_empty"}, 32'(aempty), 32'h1);
    chk({tag, ".almost_full"}, 32'(afull), 32'h0);
    tick();
    chk({tag, ".later_count"}, 32'(count), 32'd0);
    chk({tag, ".later_tvalid"}, 32'(m_tvalid), 32'h0);
  endtask

  task automatic run_latency();
    drive(1'b1, 16'hABCD, 1'b1, 1'b0);
    #1;
    chk("lat.no_bypass", 32'(m_tvalid), 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("lat.tvalid_n1", 32'(m_tvalid), 32'h1);
    chk("lat.tdata_n1", 32'(m_tdata), 32'h0000ABCD);
    chk("lat.tlast_n1", 32'(m_tlast), 32'h1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("lat.after_read_tvalid", 32'(m_tvalid), 32'h0);
    chk("lat.after_read_count", 32'(count), 32'd0);
  endtask

`ifdef AXIS_FIFO_PKT_MODE_EN
  task automatic run_pkt();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      tick();
      chk("pkt.partial_tvalid", 32'(m_tvalid), 32'h0);
    end
    drive(1'b1, 16'h0004, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pkt.complete_tvalid", 32'(m_tvalid), 32'h1);
    chk("pkt.complete_tdata", 32'(m_tdata), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      #1;
      chk("pkt.drain_tdata", 32'(m_tdata), 32'(i));
      @(posedge clk);
      #1;
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pkt.drained_tvalid", 32'(m_tvalid), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
      tick();
      chk("pkt.long_tvalid", 32'(m_tvalid), 32'(i == 8));
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pkt.flush_count", 32'(count), 32'd0);
  endtask
`endif

  initial begin
    rstn  = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
`ifdef AXIS_FIFO_PKT_MODE_EN
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.m_tvalid", 32'(m_tvalid), 32'h0);
    run_pkt();
`else
    run_table();
    run_wrap();
    run_clear(1'b0);
    run_clear(1'b1);
    run_latency();
`endif
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
Parametrised single-clock FIFO with AXI-Stream slave and master interfaces. It replaces the plain wr_en/rd_en FIFO in the SERDES datapath. Improvements over that FIFO:
- uses all DEPTH entries
- first-word-fall-through (FWFT) output
- occupancy count and almost-full/almost-empty flags
- synchronous flush
Sits between the deserialiser framer and downstream AXIS consumers.

Parameters:
DWIDTH, 16, tdata width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value (1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserts when count <= this value (0..DEPTH-1)

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents; active-high
s_axis_tdata  input  DWIDTH  write data
s_axis_tlast  input  1  packet end marker, stored with data
s_axis_tvalid  input  1  write data valid
s_axis_tready  output  1  FIFO can accept a beat
m_axis_tdata  output  DWIDTH  head-of-FIFO data
m_axis_tlast  output  1  head-of-FIFO last marker
m_axis_tvalid  output  1  head entry valid
m_axis_tready  input  1  consumer accepts head
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x (DWIDTH+1): data plus tlast.
  - Write and read pointers are $clog2(DEPTH)+1 bits.
  - Full: MSBs differ and lower bits are equal. Empty: pointers are equal. All DEPTH entries are usable.
- Handshake:
  - Write fires when s_axis_tvalid && s_axis_tready.
  - Read fires when m_axis_tvalid && m_axis_tready.
  - s_axis_tready = !full. m_axis_tvalid = !empty. Both derive only from registered state; no combinational path from m_axis_tready to s_axis_tready or from s_axis_tvalid to m_axis_tvalid.
- FWFT: m_axis_tdata/tlast always present the entry at the read pointer; they are undefined (don't-care) while m_axis_tvalid=0.
- Latency:
  - A beat written in cycle N is visible with m_axis_tvalid=1 in cycle N+1 when the FIFO was empty. There is no same-cycle bypass.
  - Read-to-tready latency is 1: a read in cycle N while full gives s_axis_tready=1 in cycle N+1.
- Simultaneous read and write:
  - Both fire in the same cycle; count is unchanged and both pointers advance.
  - At full only a read can fire (tready=0).
  - At empty only a write can fire (tvalid=0).
- Pointer wrap: pointers increment modulo 2*DEPTH; the memory index is the lower $clog2(DEPTH) bits.
- Count:
  - count is a register: +1 on write-only, -1 on read-only, unchanged otherwise.
  - It must always equal wptr-rptr (mod 2*DEPTH); the bench checks this.
- Flags: almost_full and almost_empty are combinational from the count register, so they update in the same cycle as count.
- Reset (rstn=0 at a clock edge):
  - Pointers=0 and count=0.
  - Resulting outputs: s_axis_tready=1, m_axis_tvalid=0, almost_full=0, almost_empty=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored beats; a handshake presented in the reset cycle is ignored.
- Flush: same effect as reset, but is lower priority than rstn. Any write or read in the flush cycle is discarded and no pointer advances from it.
- No overflow or underflow is possible; illegal writes and reads are blocked by the handshake.

Optional Feature:
Macro AXIS_FIFO_PKT_MODE_EN.
- Defined:
  - A packet counter tracks complete packets stored: +1 on a write with tlast=1, -1 on a read with tlast=1.
  - m_axis_tvalid = !empty && (pkt_cnt > 0 || full).
  - The full term is a forced release that prevents deadlock on packets longer than DEPTH.
  - flush and reset clear pkt_cnt.
- Undefined: m_axis_tvalid = !empty; no packet counter is instantiated.

Test Plan:
1. Reset, then write 0x0001..0x0008 with m_axis_tready=0, DEPTH=8:
   - 8 beats accepted; s_axis_tready=0 after the 8th; count=8, almost_full=1.
   - 9th beat 0x0009 is held and not accepted.
2. From full, assert m_axis_tready=1 with tvalid continuous:
   - Reads 0x0001..0x0008 in order.
   - tready returns 1 one cycle after the first read.
   - Finally count=0, almost_empty=1, m_axis_tvalid=0.
3. Write 20 beats with continuous simultaneous read at half occupancy:
   - Count stays at 4 through pointer wrap.
   - Output order is exact; tlast on beat 20 appears on the output.
4. Write 3 beats, then flush=1 with s_axis_tvalid=1 in the same cycle:
   - Next cycle count=0 and m_axis_tvalid=0; the flush-cycle beat is not stored.
   - Repeat with rstn=0 instead: same result.
5. Empty FIFO, write 0xABCD in cycle N:
   - m_axis_tvalid=1 with tdata=0xABCD in cycle N+1, not in cycle N.
6. PKT_MODE_EN:
   - Write 3 beats without tlast: m_axis_tvalid stays 0. Write a 4th beat with tlast: tvalid=1 next cycle.
   - Write 8 beats without tlast: tvalid=1 once full.
